// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the generic pipeline boundary stage.
// Holds the occupancy state encoding, the default NOP control value,
// and a helper that maps occupancy to the number of held entries.
package pipe_pkg;

  // Occupancy of the stage: nothing, main entry only, main plus skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Default control word for an invalid slot; mirrors Ctrl_NOP of the opcode table.
  localparam logic [3:0] CTRL_NOP = 4'hF;

  // Number of valid entries held for a given occupancy state.
  function automatic logic [1:0] held_entries(input state_t s);
    case (s)
      ST_ONE:  held_entries = 2'd1;
      ST_FULL: held_entries = 2'd2;
      default: held_entries = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating event counter: adds 0..2 per cycle, sticks at all-ones.
// Latency: count visible the cycle after the increment is presented.
// Backpressure: none; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [1:0]   inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   sum;

  // Next count: clear first, otherwise add with saturation on carry-out.
  always_comb begin
    sum   = {1'b0, cnt_q} + (W+1)'(inc_i);
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (sum[W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[W-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic pipeline boundary register with 2-entry skid buffer, flush and stats.
// Latency: 1 cycle from accept to out_valid_o; 1 entry/cycle sustained.
// Backpressure: in_ready_o is registered (!skid valid); out_ready_i never reaches it combinationally.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 4,
  parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(CTRL_NOP),
  parameter int                CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              flush_i,
  input  logic              clr_cnt_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  state_t            state_q;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;

  logic       accept;
  logic       consume;
  logic [1:0] stall_inc;
  logic [1:0] flush_inc;

  assign accept  = in_valid_i & in_ready_q;
  assign consume = out_valid_o & out_ready_i;

  // Occupancy FSM and entry registers; flush empties the stage and drops any incoming entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= NOP_CTRL;
      main_data_q <= '0;
      skid_ctrl_q <= NOP_CTRL;
      skid_data_q <= '0;
    end else if (flush_i) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= NOP_CTRL;
      main_data_q <= '0;
      skid_ctrl_q <= NOP_CTRL;
      skid_data_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q     <= ST_ONE;
            main_ctrl_q <= in_ctrl_i;
            main_data_q <= in_data_i;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_ctrl_q <= in_ctrl_i;
            main_data_q <= in_data_i;
          end else if (accept) begin
            state_q     <= ST_FULL;
            in_ready_q  <= 1'b0;
            skid_ctrl_q <= in_ctrl_i;
            skid_data_q <= in_data_i;
          end else if (consume) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= NOP_CTRL;
            main_data_q <= '0;
          end
        end
        ST_FULL: begin
          // Skid always drains into main, so ordering stays FIFO.
          if (consume) begin
            state_q     <= ST_ONE;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            skid_ctrl_q <= NOP_CTRL;
            skid_data_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          main_ctrl_q <= NOP_CTRL;
          main_data_q <= '0;
          skid_ctrl_q <= NOP_CTRL;
          skid_data_q <= '0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_ctrl_o  = main_ctrl_q;
  assign out_data_o  = main_data_q;

  // Stall: output presented but not taken; flushed entries count separately.
  // Flushed: held entries minus the one delivered in the same cycle.
  always_comb begin
    stall_inc = {1'b0, out_valid_o & ~out_ready_i & ~flush_i};
    flush_inc = 2'd0;
    if (flush_i) begin
      flush_inc = held_entries(state_q) - {1'b0, consume};
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_cnt_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_cnt_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed table, corner sequences, random traffic
// against a queue-based reference model. Two instances share stimulus:
// 16-bit counters and 3-bit counters (saturation).
module tb_pipe_skid_stage;

  localparam int         DW  = 32;
  localparam int         CW  = 4;
  localparam logic [3:0] NOP = 4'hF;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          flush;
  logic          clr;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall16, fl16;

  logic          in_ready3, out_valid3;
  logic [CW-1:0] out_ctrl3;
  logic [DW-1:0] out_data3;
  logic [2:0]    stall3, fl3;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ctrl_i(in_ctrl), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_ctrl_o(out_ctrl), .out_data_o(out_data), .out_ready_i(out_ready),
    .flush_i(flush), .clr_cnt_i(clr), .stall_cnt_o(stall16), .flush_cnt_o(fl16)
  );

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .CNT_W(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ctrl_i(in_ctrl), .in_data_i(in_data), .in_ready_o(in_ready3),
    .out_valid_o(out_valid3), .out_ctrl_o(out_ctrl3), .out_data_o(out_data3), .out_ready_i(out_ready),
    .flush_i(flush), .clr_cnt_i(clr), .stall_cnt_o(stall3), .flush_cnt_o(fl3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [CW+DW-1:0] mq[$];
  int m_st16, m_fl16, m_st3, m_fl3;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_st16 = 0; m_fl16 = 0; m_st3 = 0; m_fl3 = 0;
  endtask

  // One clock edge of the stage, described as a bounded FIFO of depth 2.
  task automatic model_step();
    int  n;
    bit  acc, con;
    n   = mq.size();
    acc = in_valid && (n < 2);
    con = (n > 0) && out_ready;
    if (clr) begin
      m_st16 = 0; m_fl16 = 0; m_st3 = 0; m_fl3 = 0;
    end else begin
      if (flush) begin
        m_fl16 = sat(m_fl16 + n - int'(con), 65535);
        m_fl3  = sat(m_fl3  + n - int'(con), 7);
      end else if (n > 0 && !out_ready) begin
        m_st16 = sat(m_st16 + 1, 65535);
        m_st3  = sat(m_st3  + 1, 7);
      end
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back({in_ctrl, in_data});
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit          ev;
    logic [3:0]  ec;
    logic [31:0] ed;
    ev = (mq.size() > 0);
    ec = ev ? mq[0][CW+DW-1:DW] : NOP;
    ed = ev ? mq[0][DW-1:0] : 32'h0;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_ctrl",  32'(out_ctrl),  32'(ec));
    chk("out_data",  out_data,       ed);
    chk("in_ready",  32'(in_ready),  32'(mq.size() < 2));
    chk("stall16",   32'(stall16),   m_st16);
    chk("flush16",   32'(fl16),      m_fl16);
    chk("out_valid3", 32'(out_valid3), 32'(ev));
    chk("out_ctrl3",  32'(out_ctrl3),  32'(ec));
    chk("out_data3",  out_data3,       ed);
    chk("in_ready3",  32'(in_ready3),  32'(mq.size() < 2));
    chk("stall3",     32'(stall3),     m_st3);
    chk("flush3",     32'(fl3),        m_fl3);
  endtask

  // Drive one cycle of inputs from a falling edge, step the model at the rising edge, check at the next falling edge.
  task automatic cyc(input bit vi, input logic [3:0] c, input logic [31:0] d,
                     input bit ordy, input bit fl, input bit cl);
    in_valid = vi; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; clr = cl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          vi;
    logic [31:0] d;
    bit          ordy;
    bit          fl;
    bit          cl;
    bit          ev;
    logic [31:0] ed;
    bit          er;
    int          es;
    int          ef;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // stimulus: vi, data, out_ready, flush, clr | expected after edge: valid, data, in_ready, stall16, flush16
    tbl[0]  = '{1, 32'h11, 1, 0, 0,  1, 32'h11, 1, 0, 0};
    tbl[1]  = '{1, 32'h22, 1, 0, 0,  1, 32'h22, 1, 0, 0};
    tbl[2]  = '{1, 32'h33, 1, 0, 0,  1, 32'h33, 1, 0, 0};
    tbl[3]  = '{0, 32'h00, 1, 0, 0,  0, 32'h00, 1, 0, 0};
    tbl[4]  = '{1, 32'hA1, 0, 0, 0,  1, 32'hA1, 1, 0, 0};
    tbl[5]  = '{1, 32'hA2, 0, 0, 0,  1, 32'hA1, 0, 1, 0};
    tbl[6]  = '{0, 32'h00, 0, 0, 0,  1, 32'hA1, 0, 2, 0};
    tbl[7]  = '{0, 32'h00, 0, 0, 0,  1, 32'hA1, 0, 3, 0};
    tbl[8]  = '{0, 32'h00, 0, 0, 0,  1, 32'hA1, 0, 4, 0};
    tbl[9]  = '{0, 32'h00, 1, 0, 0,  1, 32'hA2, 1, 4, 0};
    tbl[10] = '{0, 32'h00, 1, 0, 0,  0, 32'h00, 1, 4, 0};
    tbl[11] = '{1, 32'hB1, 0, 0, 0,  1, 32'hB1, 1, 4, 0};
    tbl[12] = '{1, 32'hB2, 0, 0, 0,  1, 32'hB1, 0, 5, 0};
    tbl[13] = '{1, 32'hFF, 0, 1, 0,  0, 32'h00, 1, 5, 2};
    tbl[14] = '{1, 32'hC1, 1, 0, 0,  1, 32'hC1, 1, 5, 2};
    tbl[15] = '{1, 32'h05, 1, 1, 0,  0, 32'h00, 1, 5, 2};
    tbl[16] = '{0, 32'h00, 1, 0, 0,  0, 32'h00, 1, 5, 2};
    tbl[17] = '{0, 32'h00, 1, 0, 1,  0, 32'h00, 1, 0, 0};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0; clr = 1'b0;
    model_reset();

    // Reset state.
    @(negedge clk);
    check_model();
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].vi, 4'h3, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].cl);
      chk($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.data", i),  out_data,       tbl[i].ed);
      chk($sformatf("tbl%0d.ready", i), 32'(in_ready),  32'(tbl[i].er));
      chk($sformatf("tbl%0d.stall", i), 32'(stall16),   tbl[i].es);
      chk($sformatf("tbl%0d.flush", i), 32'(fl16),      tbl[i].ef);
    end

    // Stall saturation on the 3-bit counter, then clear while still stalled.
    cyc(1, 4'h2, 32'hD1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 4'h0, 32'h0, 0, 0, 0);
    chk("sat.stall3", 32'(stall3), 7);
    chk("sat.stall16", 32'(stall16), 10);
    cyc(0, 4'h0, 32'h0, 0, 0, 1);
    chk("clr.stall3", 32'(stall3), 0);
    cyc(0, 4'h0, 32'h0, 0, 0, 0);
    chk("post_clr.stall3", 32'(stall3), 1);
    cyc(0, 4'h0, 32'h0, 1, 0, 0);

    // Asynchronous reset while FULL.
    cyc(1, 4'h4, 32'hE1, 0, 0, 0);
    cyc(1, 4'h5, 32'hE2, 0, 0, 0);
    chk("pre_rst.ready", 32'(in_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", 32'(out_valid), 0);
    chk("arst.ready", 32'(in_ready), 1);
    chk("arst.ctrl",  32'(out_ctrl), 32'(NOP));
    chk("arst.data",  out_data, 0);
    chk("arst.stall", 32'(stall16), 0);
    chk("arst.flush", 32'(fl16), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_model();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) < 65),
          4'($urandom_range(0, 15)),
          $urandom,
          ($urandom_range(0, 99) < 60),
          ($urandom_range(0, 99) < 6),
          ($urandom_range(0, 99) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
